// File: rtl/next_piece_queue.sv
// ---------------------------------------------------------------------------
// next_piece_queue
//
// Keeps a short FIFO of upcoming tetromino IDs (1..7) topped up from rand_gen.
// A small refill FSM pulses rand_gen's drop input (refill_req) and samples
// rand_blk exactly REFILL_LAT cycles later. Only one refill is in flight at a
// time. The head of the queue is handed to the spawn logic as the active piece
// (cur_blk). The whole queue is exposed on the preview bus.
//
// Optional feature macro: NEXT_PIECE_HOLD_EN
//   When defined, a hold slot lets the player park the active piece once per
//   spawn. When undefined, hold_req is ignored and hold_blk/hold_locked read 0.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rand_blk     piece ID from rand_gen (sampled in the CAP state)
//   refill_req   one-cycle pulse to rand_gen drop
//   spawn_req    request to pop the queue head into the active slot
//   cur_blk      active piece ID, 0 = none
//   cur_valid    cur_blk holds a live piece
//   spawn_miss   one-cycle pulse: spawn_req seen while the queue was empty
//   preview      queue contents, head in [BLK_W-1:0], empty slots read 0
//   q_count      number of valid queue entries (0..DEPTH)
//   hold_req     swap active piece with the hold slot (hold feature only)
//   hold_blk     held piece ID, 0 = empty
//   hold_locked  hold already used for the current active piece
//
// REFILL_LAT is expected to be at least 2 (rand_gen needs 5).
// ---------------------------------------------------------------------------
module next_piece_queue #(
    parameter int DEPTH      = 4,
    parameter int BLK_W      = 4,
    parameter int REFILL_LAT = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BLK_W-1:0]         rand_blk,
    output logic                     refill_req,
    input  logic                     spawn_req,
    output logic [BLK_W-1:0]         cur_blk,
    output logic                     cur_valid,
    output logic                     spawn_miss,
    output logic [DEPTH*BLK_W-1:0]   preview,
    output logic [3:0]               q_count,
    input  logic                     hold_req,
    output logic [BLK_W-1:0]         hold_blk,
    output logic                     hold_locked
);

    localparam int             LAT_W    = $clog2(REFILL_LAT) + 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(REFILL_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CAP
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [BLK_W-1:0]   queue_q [DEPTH];
    logic [BLK_W-1:0]   queue_d [DEPTH];
    logic [3:0]         count_q, count_d;
    logic [BLK_W-1:0]   cur_blk_q, cur_blk_d;
    logic               cur_valid_q, cur_valid_d;
    logic               spawn_miss_q, spawn_miss_d;

    logic               push;
    logic               pop;
    logic               blk_ok;
    logic               have_entry;
    logic [3:0]         base;

`ifdef NEXT_PIECE_HOLD_EN
    logic [BLK_W-1:0]   hold_blk_q, hold_blk_d;
    logic               hold_locked_q, hold_locked_d;
`else
    logic               unused_hold_req;
    assign unused_hold_req = hold_req;
`endif

    assign blk_ok     = (rand_blk != '0) && (rand_blk <= BLK_W'(7));
    assign have_entry = (count_q != 4'd0);

    // Refill FSM next-state. The full check lives only in IDLE, and only this
    // FSM pushes, so a capture can never overflow the queue.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q < 4'(DEPTH)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                lat_d   = LAT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q <= LAT_W'(1)) begin
                    lat_d   = '0;
                    state_d = ST_CAP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_CAP: begin
                push    = blk_ok;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign refill_req = (state_q == ST_REQ);

    // Spawn / hold decisions. Spawn has priority over hold; a push landing in
    // the same cycle cannot satisfy a spawn against an empty queue.
    always_comb begin
        pop          = 1'b0;
        cur_blk_d    = cur_blk_q;
        cur_valid_d  = cur_valid_q;
        spawn_miss_d = 1'b0;
`ifdef NEXT_PIECE_HOLD_EN
        hold_blk_d    = hold_blk_q;
        hold_locked_d = hold_locked_q;
`endif
        if (spawn_req) begin
            if (have_entry) begin
                pop         = 1'b1;
                cur_blk_d   = queue_q[0];
                cur_valid_d = 1'b1;
`ifdef NEXT_PIECE_HOLD_EN
                hold_locked_d = 1'b0;
`endif
            end else begin
                spawn_miss_d = 1'b1;
            end
        end
`ifdef NEXT_PIECE_HOLD_EN
        else if (hold_req && cur_valid_q && !hold_locked_q) begin
            if (hold_blk_q == '0) begin
                // Empty hold slot: park the active piece and pull the head.
                if (have_entry) begin
                    pop           = 1'b1;
                    hold_blk_d    = cur_blk_q;
                    cur_blk_d     = queue_q[0];
                    hold_locked_d = 1'b1;
                end
            end else begin
                hold_blk_d    = cur_blk_q;
                cur_blk_d     = hold_blk_q;
                hold_locked_d = 1'b1;
            end
        end
`endif
    end

    // Queue update: shift toward the head on pop, then write the captured
    // piece into the first free slot after the shift.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            queue_d[i] = queue_q[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                queue_d[i] = queue_q[i + 1];
            end
            queue_d[DEPTH-1] = '0;
        end
        base = count_q - {3'b000, pop};
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (base == 4'(i)) begin
                    queue_d[i] = rand_blk;
                end
            end
        end
        count_d = base + {3'b000, push};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lat_q        <= '0;
            count_q      <= '0;
            cur_blk_q    <= '0;
            cur_valid_q  <= 1'b0;
            spawn_miss_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            count_q      <= count_d;
            cur_blk_q    <= cur_blk_d;
            cur_valid_q  <= cur_valid_d;
            spawn_miss_q <= spawn_miss_d;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= queue_d[i];
            end
        end
    end

`ifdef NEXT_PIECE_HOLD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_blk_q    <= '0;
            hold_locked_q <= 1'b0;
        end else begin
            hold_blk_q    <= hold_blk_d;
            hold_locked_q <= hold_locked_d;
        end
    end

    assign hold_blk    = hold_blk_q;
    assign hold_locked = hold_locked_q;
`else
    assign hold_blk    = '0;
    assign hold_locked = 1'b0;
`endif

    always_comb begin
        preview = '0;
        for (int i = 0; i < DEPTH; i++) begin
            preview[i*BLK_W +: BLK_W] = queue_q[i];
        end
    end

    assign cur_blk    = cur_blk_q;
    assign cur_valid  = cur_valid_q;
    assign spawn_miss = spawn_miss_q;
    assign q_count    = count_q;

endmodule

// File: tb/tb_next_piece_queue.sv
// Testbench for next_piece_queue. Each cycle the driver issues random inputs,
// steps a queue-based reference model and pushes the expected outputs into a
// scoreboard; an independent monitor pops and compares after every clock edge.
module tb_next_piece_queue;

   localparam int DEPTH = 4;
   localparam int BLK_W = 4;
   localparam int LAT   = 5;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b1;
   logic [BLK_W-1:0]       rand_blk = '0;
   logic                   refill_req;
   logic                   spawn_req = 1'b0;
   logic [BLK_W-1:0]       cur_blk;
   logic                   cur_valid;
   logic                   spawn_miss;
   logic [DEPTH*BLK_W-1:0] preview;
   logic [3:0]             q_count;
   logic                   hold_req = 1'b0;
   logic [BLK_W-1:0]       hold_blk;
   logic                   hold_locked;

   typedef struct packed {
      logic                   refill;
      logic [BLK_W-1:0]       cur;
      logic                   cv;
      logic                   miss;
      logic [DEPTH*BLK_W-1:0] prev;
      logic [3:0]             cnt;
      logic [BLK_W-1:0]       hold;
      logic                   locked;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model state: the piece queue as a plain list, the active and
   // held pieces, and the refill timeline expressed as absolute cycle numbers.
   int   pieces[$];
   int   m_cur = 0;
   bit   m_cv = 0;
   int   m_hold = 0;
   bit   m_locked = 0;
   bit   busy = 0;
   int   req_cycle = 0;
   int   cyc = 0;
   int   gen_val = 1;

   next_piece_queue #(
      .DEPTH(DEPTH),
      .BLK_W(BLK_W),
      .REFILL_LAT(LAT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rand_blk(rand_blk),
      .refill_req(refill_req),
      .spawn_req(spawn_req),
      .cur_blk(cur_blk),
      .cur_valid(cur_valid),
      .spawn_miss(spawn_miss),
      .preview(preview),
      .q_count(q_count),
      .hold_req(hold_req),
      .hold_blk(hold_blk),
      .hold_locked(hold_locked)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // One comparison: counts it, and reports a FAIL line on mismatch.
   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Compare every DUT output against one scoreboard entry.
   task automatic checkOutput(input exp_t e);
      checkValue("refill_req", 64'(refill_req), 64'(e.refill));
      checkValue("cur_blk", 64'(cur_blk), 64'(e.cur));
      checkValue("cur_valid", 64'(cur_valid), 64'(e.cv));
      checkValue("spawn_miss", 64'(spawn_miss), 64'(e.miss));
      checkValue("preview", 64'(preview), 64'(e.prev));
      checkValue("q_count", 64'(q_count), 64'(e.cnt));
      checkValue("hold_blk", 64'(hold_blk), 64'(e.hold));
      checkValue("hold_locked", 64'(hold_locked), 64'(e.locked));
   endtask

   // rand_gen stand-in: cycles 1..7, occasionally replaced by an invalid ID.
   function automatic logic [BLK_W-1:0] nextBlk();
      int r;
      logic [BLK_W-1:0] v;
      r = int'($urandom_range(0, 9));
      if (r == 0) v = '0;
      else if (r == 1) v = BLK_W'($urandom_range(8, 15));
      else v = BLK_W'(gen_val);
      gen_val = (gen_val == 7) ? 1 : gen_val + 1;
      return v;
   endfunction

   // Drive one cycle of inputs at the falling edge, advance the reference
   // model by one cycle and queue the outputs expected after the next edge.
   task automatic applyStimulus(input bit spawn, input bit hold, input logic [BLK_W-1:0] rblk);
      int   old_n;
      int   t;
      bit   do_push;
      exp_t e;
      @(negedge clk);
      rst_n     = 1'b1;
      spawn_req = spawn;
      hold_req  = hold;
      rand_blk  = rblk;

      old_n   = pieces.size();
      do_push = 1'b0;
      if (!busy) begin
         if (old_n < DEPTH) begin
            busy      = 1'b1;
            req_cycle = cyc + 1;
         end
      end else if (cyc == req_cycle + LAT) begin
         busy    = 1'b0;
         do_push = (rblk >= 1) && (rblk <= 7);
      end

      e.miss = 1'b0;
      if (spawn) begin
         if (old_n > 0) begin
            m_cur    = pieces.pop_front();
            m_cv     = 1'b1;
            m_locked = 1'b0;
         end else begin
            e.miss = 1'b1;
         end
      end
`ifdef NEXT_PIECE_HOLD_EN
      else if (hold && m_cv && !m_locked) begin
         if (m_hold == 0) begin
            if (old_n > 0) begin
               m_hold   = m_cur;
               m_cur    = pieces.pop_front();
               m_locked = 1'b1;
            end
         end else begin
            t        = m_cur;
            m_cur    = m_hold;
            m_hold   = t;
            m_locked = 1'b1;
         end
      end
`endif
      if (do_push) pieces.push_back(int'(rblk));

      e.prev = '0;
      for (int i = 0; i < pieces.size(); i++) begin
         e.prev[i*BLK_W +: BLK_W] = BLK_W'(pieces[i]);
      end
      e.refill = busy && (req_cycle == cyc + 1);
      e.cur    = BLK_W'(m_cur);
      e.cv     = m_cv;
      e.cnt    = 4'(pieces.size());
      e.hold   = BLK_W'(m_hold);
      e.locked = m_locked;
      exp_q.push_back(e);
      cyc++;
   endtask

   // Assert reset right now, check that every output clears immediately, and
   // restart the model. Release happens in the next applyStimulus call.
   task automatic applyReset();
      rst_n = 1'b0;
      rand_blk = BLK_W'(5);
      #1;
      checkValue("rst refill_req", 64'(refill_req), 64'd0);
      checkValue("rst cur_blk", 64'(cur_blk), 64'd0);
      checkValue("rst cur_valid", 64'(cur_valid), 64'd0);
      checkValue("rst spawn_miss", 64'(spawn_miss), 64'd0);
      checkValue("rst preview", 64'(preview), 64'd0);
      checkValue("rst q_count", 64'(q_count), 64'd0);
      checkValue("rst hold_blk", 64'(hold_blk), 64'd0);
      checkValue("rst hold_locked", 64'(hold_locked), 64'd0);
      pieces.delete();
      m_cur = 0; m_cv = 0; m_hold = 0; m_locked = 0;
      busy = 0; req_cycle = 0; cyc = 0;
      repeat (2) @(negedge clk);
   endtask

   // Monitor: after each rising edge, pop one expected entry and compare.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      end
   end

   // Main sequence: fill from reset, random traffic, drain to empty, reset
   // during an outstanding refill, then more random traffic.
   initial begin
      bit hit;
      #2;
      applyReset();

      repeat (40) applyStimulus(1'b0, 1'b0, BLK_W'(gen_val == 7 ? 1 : gen_val + 1));

      repeat (600) applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, nextBlk());

      repeat (30) applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, nextBlk());

      repeat (600) applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, nextBlk());

      repeat (2) applyStimulus(1'b1, 1'b0, nextBlk());
      hit = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (busy && cyc > req_cycle && cyc < req_cycle + LAT) begin
            hit = 1'b1;
            break;
         end
         applyStimulus(1'b0, 1'b0, nextBlk());
      end
      checkValue("reach WAIT before reset", 64'(hit), 64'd1);
      @(posedge clk);
      #2;
      applyReset();

      repeat (60) applyStimulus(1'b0, 1'b0, BLK_W'(3));

      repeat (300) applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, nextBlk());

      @(negedge clk);
      spawn_req = 1'b0;
      hold_req  = 1'b0;
      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
      #3;
      checkValue("scoreboard drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
